// File: rtl/shift_pkg.sv
// Shared types and constants for the variable-amount shift sequencer.
package shift_pkg;

  localparam int DATA_W    = 32;
  localparam int AMT_W     = 5;
  localparam int STAGE_CNT = 5;
  localparam int IDX_W     = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits of the amount strictly below stage idx (those still to be applied).
  function automatic logic [AMT_W-1:0] lower_mask(input logic [IDX_W-1:0] idx);
    lower_mask = AMT_W'((32'd1 << idx) - 32'd1);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/ready handshake and data bus between the execute stage and the shift sequencer.
interface shift_sequencer_if;
  import shift_pkg::*;

  logic              ctrl_shift;
  logic              ctrl_dir;
  logic [AMT_W-1:0]  ctrl_shiftamt;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_result;
  logic              data_resultRDY;
  logic              data_busy;

  modport master (
    output ctrl_shift, ctrl_dir, ctrl_shiftamt, data_operandA,
    input  data_result, data_resultRDY, data_busy
  );

  modport slave (
    input  ctrl_shift, ctrl_dir, ctrl_shiftamt, data_operandA,
    output data_result, data_resultRDY, data_busy
  );

endinterface

// File: rtl/shift_stage.sv
// One combinational shift stage: logical left or arithmetic right by 2^idx.
module shift_stage
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              dir_i,
  output logic [DATA_W-1:0] data_o
);

  // Each loop iteration is a fixed-distance shifter; idx selects one of them.
  always_comb begin
    data_o = data_i;
    for (int i = 0; i < STAGE_CNT; i++) begin
      if (idx_i == IDX_W'(i)) begin
        if (dir_i == DIR_RIGHT) data_o = DATA_W'($signed(data_i) >>> (1 << i));
        else                    data_o = data_i << (1 << i);
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter applying the 16/8/4/2/1 stages one per cycle.
// Build option SHIFT_EARLY_EXIT_EN: finish as soon as no lower amount bits remain.
//
// state | meaning
// IDLE  | waiting for ctrl_shift; result held
// SHIFT | applying stage idx (4 down to 0) when amt_q[idx] is set
// DONE  | data_resultRDY strobe for one cycle
module shift_sequencer
  import shift_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic                dir_q, dir_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   stage_out;

  shift_stage u_stage (
    .data_i (work_q),
    .idx_i  (idx_q),
    .dir_i  (dir_q),
    .data_o (stage_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= IDX_W'(STAGE_CNT - 1);
      amt_q   <= '0;
      dir_q   <= DIR_LEFT;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    amt_d   = amt_q;
    dir_d   = dir_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (bus.ctrl_shift) begin
          work_d  = bus.data_operandA;
          amt_d   = bus.ctrl_shiftamt;
          dir_d   = bus.ctrl_dir;
          idx_d   = IDX_W'(STAGE_CNT - 1);
          state_d = SHIFT;
`ifdef SHIFT_EARLY_EXIT_EN
          if (bus.ctrl_shiftamt == '0) state_d = DONE;
`endif
        end
      end
      SHIFT: begin
        if (amt_q[idx_q]) work_d = stage_out;
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) state_d = DONE;
`ifdef SHIFT_EARLY_EXIT_EN
        if ((amt_q & lower_mask(idx_q)) == '0) state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_result    = work_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer; honours SHIFT_EARLY_EXIT_EN for latency expectations.
module tb_shift_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  shift_sequencer_if bus_if();

  shift_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Latency in cycles counted with the start cycle as cycle 0 and the RDY cycle as cycle N.
  function automatic int exp_latency(input logic [4:0] amt);
`ifdef SHIFT_EARLY_EXIT_EN
    if (amt == 5'd0) return 1;
    for (int p = 0; p < 5; p++) if (amt[p]) return 6 - p;
    return 6;
`else
    return 6;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] op, input logic [4:0] amt, input logic dir);
    bus_if.ctrl_shift    = 1'b1;
    bus_if.data_operandA = op;
    bus_if.ctrl_shiftamt = amt;
    bus_if.ctrl_dir      = dir;
    tick();
    bus_if.ctrl_shift    = 1'b0;
    bus_if.data_operandA = 32'h5A5A_A5A5;
    bus_if.ctrl_shiftamt = 5'd0;
    bus_if.ctrl_dir      = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] amt,
                        input logic dir, input logic [31:0] exp_res);
    int n;
    drive_start(op, amt, dir);
    n = 0;
    while (!bus_if.data_resultRDY && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n + 1), 32'(exp_latency(amt)));
    check({tag, "_result"}, bus_if.data_result, exp_res);
    check({tag, "_busy_in_done"}, 32'(bus_if.data_busy), 32'd1);
    tick();
    check({tag, "_rdy_oneshot"}, 32'(bus_if.data_resultRDY), 32'd0);
    check({tag, "_busy_after"}, 32'(bus_if.data_busy), 32'd0);
    check({tag, "_result_held"}, bus_if.data_result, exp_res);
  endtask

  typedef struct {
    logic [31:0] op;
    logic [4:0]  amt;
    logic        dir;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h0000_0001, 5'd5,  1'b0, 32'h0000_0020},
    '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF},
    '{32'h4000_0000, 5'd30, 1'b1, 32'h0000_0001},
    '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF},
    '{32'h0000_FFFF, 5'd16, 1'b0, 32'hFFFF_0000},
    '{32'h0000_FFFF, 5'd1,  1'b0, 32'h0001_FFFE},
    '{32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000},
    '{32'h1234_5679, 5'd31, 1'b0, 32'h8000_0000},
    '{32'h7FFF_FFFF, 5'd3,  1'b1, 32'h0FFF_FFFF},
    '{32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002}
  };

  initial begin
    int rdy_cnt;
    bus_if.ctrl_shift    = 1'b0;
    bus_if.ctrl_dir      = 1'b0;
    bus_if.ctrl_shiftamt = 5'd0;
    bus_if.data_operandA = 32'h0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_result", bus_if.data_result, 32'h0);
    check("reset_rdy", 32'(bus_if.data_resultRDY), 32'd0);
    check("reset_busy", 32'(bus_if.data_busy), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].dir, vecs[i].res);
    end

    // Second start two cycles into the first must be ignored.
    drive_start(32'h0000_0003, 5'd2, 1'b0);
    rdy_cnt = 0;
    tick();
    bus_if.ctrl_shift    = 1'b1;
    bus_if.data_operandA = 32'h0000_0001;
    bus_if.ctrl_shiftamt = 5'd1;
    tick();
    bus_if.ctrl_shift    = 1'b0;
    if (bus_if.data_resultRDY) rdy_cnt++;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus_if.data_resultRDY) rdy_cnt++;
    end
    check("busy_start_rdy_count", 32'(rdy_cnt), 32'd1);
    check("busy_start_result", bus_if.data_result, 32'h0000_000C);
    check("busy_start_idle", 32'(bus_if.data_busy), 32'd0);

    // Reset in the third shift cycle aborts the operation.
    drive_start(32'h0000_0001, 5'd3, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_result", bus_if.data_result, 32'h0);
    check("midreset_busy", 32'(bus_if.data_busy), 32'd0);
    check("midreset_rdy", 32'(bus_if.data_resultRDY), 32'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus_if.data_resultRDY) rdy_cnt++;
    end
    check("midreset_no_rdy", 32'(rdy_cnt), 32'd0);
    run_op("after_reset", 32'h0000_0005, 5'd2, 1'b0, 32'h0000_0014);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
